mem_trace_player: RTL and testbench
===================================

Name: mem_trace_player

Overview:
- Synthesizable replayer for per-lane memory request traces, the producer side of the trace logging flow.
- Accepts a stream of trace records, one record at a time, from a loader such as a DPI reader or a scratchpad DMA.
- Holds each record until the local cycle counter reaches the record's timestamp, then drives it as a request on the selected lane's valid/ready port.
- Sits in front of the coalescer/memory under test, in place of the cores. Its output lane packing matches the logger's input packing.

Parameters:
NUM_LANES, 4, number of request lanes (1..32)
DATA_WIDTH, 64, width of address, data and cycle fields
SOURCEID_WIDTH, 32, width of source id per lane
LOGSIZE_WIDTH, 8, width of log2 size per lane
LANE_ID_WIDTH, 5, width of the rec_lane_id field

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-low reset (0 = in reset)
rec_valid  in  1  trace record present
rec_ready  out  1  record accepted this cycle when rec_valid && rec_ready
rec_cycle  in  DATA_WIDTH  earliest issue cycle
rec_lane_id  in  LANE_ID_WIDTH  target lane
rec_source  in  SOURCEID_WIDTH  source id
rec_address  in  DATA_WIDTH  byte address
rec_is_store  in  1  1 = store
rec_size  in  LOGSIZE_WIDTH  log2 bytes
rec_data  in  DATA_WIDTH  store data
rec_last  in  1  final record of trace
req_valid  out  NUM_LANES  per-lane request valid, LSB = lane 0
req_ready  in  NUM_LANES  per-lane ready
req_source  out  SOURCEID_WIDTH*NUM_LANES  packed, LSB = lane 0
req_address  out  DATA_WIDTH*NUM_LANES  packed
req_is_store  out  NUM_LANES  per lane
req_size  out  LOGSIZE_WIDTH*NUM_LANES  packed
req_data  out  DATA_WIDTH*NUM_LANES  packed
done  out  1  trace fully issued and drained (sticky)
err_bad_lane  out  1  sticky: a record with lane_id >= NUM_LANES was dropped
stall_cycles  out  32  saturating count of cycles the head record was due but blocked

Behaviour:
- Reset (reset==0 at posedge):
  - cycle_counter=0; head_valid=0; all lane slots empty; done=0; err_bad_lane=0; stall_cycles=0; last_seen=0.
  - Outputs during reset: req_valid=0, rec_ready=0.
- cycle_counter: increments by 1 every cycle out of reset, wraps modulo 2^DATA_WIDTH. Cycle 0 is the first cycle after reset deasserts, matching the logger's counter.
- Head register: one-entry buffer for the incoming record.
  - rec_ready = !head_valid || head_fire.
  - Accept when rec_valid && rec_ready: capture all rec_* fields; record rec_last into last_seen on accept.
- Due: head_valid && head.cycle <= cycle_counter (unsigned compare).
- Slot free(l): !slot_valid[l] || req_ready[l].
- head_fire = due && (lane_id >= NUM_LANES || slot free(lane_id)).
- On fire with a valid lane: slot[lane_id] loads head fields; slot_valid set next cycle. Latency from due to req_valid is 1 cycle.
- On fire with lane_id >= NUM_LANES: record discarded; err_bad_lane <= 1.
- At most one record issues per cycle. Records sharing a timestamp issue on consecutive cycles, in input order. A blocked head blocks all later records (strict order).
- stall_cycles: +1 each cycle with due && !head_fire; saturates at 2^32-1.
- Lane slot l:
  - req_valid[l] = slot_valid[l]; fields are stable while valid && !ready.
  - Cleared on req_ready[l] unless reloaded in the same cycle. A simultaneous drain and reload keeps valid=1 with the new fields.
- done <= 1 when last_seen && !head_valid && no slot valid. It stays 1 until reset.
- After done, further rec_valid is still accepted and replayed; done does not clear.
- Reset mid-operation discards the head and all slots with no request completion. The downstream block must be reset together with this one.
- rec_cycle already in the past on arrival: issues immediately (due next cycle after capture); no error.

Decomposition:
- Package mem_trace_pkg: width constants (DATA_WIDTH, SOURCEID_WIDTH, LOGSIZE_WIDTH, MAX_NUM_LANES=32) and a packed trace_rec_t struct (cycle, lane_id, source, address, is_store, size, data, last). Shared with the logger side.
- Sub-module mem_trace_lane_slot: one-entry valid/ready output register with a load port, instantiated NUM_LANES times.

Test Plan:
- Reset: hold reset=0 for 5 cycles with rec_valid=1 -> req_valid=0, rec_ready=0, done=0, stall_cycles=0. Release -> cycle_counter reads 0 in the first cycle.
- Timed issue: record {cycle=10, lane=2, addr=0x1000, load, size=2}, all ready=1 -> req_valid[2] high exactly during cycle 11 with address 0x1000; other lanes stay 0.
- Backpressure: lane 1 req_ready=0 for 20 cycles; records {cycle=5, lane=1} then {cycle=6, lane=1} -> first held stable on lane 1; second blocked; stall_cycles increments once per blocked cycle. On ready=1, the second appears the cycle after the first drains; order is preserved.
- Same-cycle fan-out: 4 records with cycle=3 to lanes 0..3 -> lanes issue on cycles 4, 5, 6, 7; stall_cycles=0.
- Bad lane: record with lane_id=7, NUM_LANES=4 -> no req_valid; err_bad_lane=1 and stays set; the next valid record issues normally.
- Completion: 3 records, third with rec_last=1, lane 0 ready delayed by 4 cycles -> done rises one cycle after the final lane-0 handshake, and stays high.

Source files
------------

// File: rtl/mem_trace_pkg.sv
// Shared trace record definitions for the replay (player) and capture (logger) sides.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package mem_trace_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int SOURCEID_WIDTH = 32;
  localparam int LOGSIZE_WIDTH  = 8;
  localparam int LANE_ID_WIDTH  = 5;
  localparam int MAX_NUM_LANES  = 32;

  // One trace record as it travels between the loader, the player and the logger.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     cycle;
    logic [LANE_ID_WIDTH-1:0]  lane_id;
    logic [SOURCEID_WIDTH-1:0] source;
    logic [DATA_WIDTH-1:0]     address;
    logic                      is_store;
    logic [LOGSIZE_WIDTH-1:0]  size;
    logic [DATA_WIDTH-1:0]     data;
    logic                      last;
  } trace_rec_t;

  // True when a lane id addresses a lane that actually exists in this instance.
  function automatic logic lane_in_range(input int unsigned lane_id, input int unsigned num_lanes);
    return (lane_id < num_lanes) && (lane_id < MAX_NUM_LANES);
  endfunction

endpackage

// File: rtl/mem_trace_lane_slot.sv
// One-entry valid/ready output register for a single request lane.
// Latency: 1 cycle from load to valid.
// Backpressure: holds fields stable while valid && !ready; a load in the drain cycle replaces the entry.
module mem_trace_lane_slot
  import mem_trace_pkg::*;
#(
  parameter int DATA_WIDTH     = mem_trace_pkg::DATA_WIDTH,
  parameter int SOURCEID_WIDTH = mem_trace_pkg::SOURCEID_WIDTH,
  parameter int LOGSIZE_WIDTH  = mem_trace_pkg::LOGSIZE_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [SOURCEID_WIDTH-1:0] load_source,
  input  logic [DATA_WIDTH-1:0]     load_address,
  input  logic                      load_is_store,
  input  logic [LOGSIZE_WIDTH-1:0]  load_size,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      ready,
  output logic                      valid,
  output logic [SOURCEID_WIDTH-1:0] source,
  output logic [DATA_WIDTH-1:0]     address,
  output logic                      is_store,
  output logic [LOGSIZE_WIDTH-1:0]  size,
  output logic [DATA_WIDTH-1:0]     data
);

  // Occupancy: a load wins over a drain so back-to-back requests keep valid high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Payload only changes on load, so it is stable for as long as the request waits.
  always_ff @(posedge clock) begin
    if (load) begin
      source   <= load_source;
      address  <= load_address;
      is_store <= load_is_store;
      size     <= load_size;
      data     <= load_data;
    end
  end

endmodule

// File: rtl/mem_trace_player.sv
// Replays timestamped trace records onto per-lane valid/ready request ports.
// Latency: a record issues 1 cycle after it becomes due (timestamp <= cycle counter).
// Backpressure: a blocked head stalls all later records; rec_ready drops while the head is held.
module mem_trace_player #(
  parameter int NUM_LANES      = 4,
  parameter int DATA_WIDTH     = mem_trace_pkg::DATA_WIDTH,
  parameter int SOURCEID_WIDTH = mem_trace_pkg::SOURCEID_WIDTH,
  parameter int LOGSIZE_WIDTH  = mem_trace_pkg::LOGSIZE_WIDTH,
  parameter int LANE_ID_WIDTH  = mem_trace_pkg::LANE_ID_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                rec_valid,
  output logic                                rec_ready,
  input  logic [DATA_WIDTH-1:0]               rec_cycle,
  input  logic [LANE_ID_WIDTH-1:0]            rec_lane_id,
  input  logic [SOURCEID_WIDTH-1:0]           rec_source,
  input  logic [DATA_WIDTH-1:0]               rec_address,
  input  logic                                rec_is_store,
  input  logic [LOGSIZE_WIDTH-1:0]            rec_size,
  input  logic [DATA_WIDTH-1:0]               rec_data,
  input  logic                                rec_last,
  output logic [NUM_LANES-1:0]                req_valid,
  input  logic [NUM_LANES-1:0]                req_ready,
  output logic [SOURCEID_WIDTH*NUM_LANES-1:0] req_source,
  output logic [DATA_WIDTH*NUM_LANES-1:0]     req_address,
  output logic [NUM_LANES-1:0]                req_is_store,
  output logic [LOGSIZE_WIDTH*NUM_LANES-1:0]  req_size,
  output logic [DATA_WIDTH*NUM_LANES-1:0]     req_data,
  output logic                                done,
  output logic                                err_bad_lane,
  output logic [31:0]                         stall_cycles
);

  import mem_trace_pkg::*;

  logic [DATA_WIDTH-1:0]     cycle_counter;
  logic                      head_valid;
  logic [DATA_WIDTH-1:0]     head_cycle;
  logic [LANE_ID_WIDTH-1:0]  head_lane;
  logic [SOURCEID_WIDTH-1:0] head_source;
  logic [DATA_WIDTH-1:0]     head_address;
  logic                      head_is_store;
  logic [LOGSIZE_WIDTH-1:0]  head_size;
  logic [DATA_WIDTH-1:0]     head_data;
  logic                      last_seen;

  logic [NUM_LANES-1:0]      slot_valid;
  logic [NUM_LANES-1:0]      slot_free;
  logic [NUM_LANES-1:0]      slot_load;
  logic                      lane_free_sel;
  logic                      head_bad;
  logic                      due;
  logic                      head_fire;
  logic                      rec_accept;

  assign slot_free  = ~slot_valid | req_ready;
  assign head_bad   = !lane_in_range(32'(head_lane), NUM_LANES);
  assign due        = head_valid && (head_cycle <= cycle_counter);
  assign head_fire  = due && (head_bad || lane_free_sel);
  assign rec_ready  = reset && (!head_valid || head_fire);
  assign rec_accept = rec_valid && rec_ready;
  assign req_valid  = slot_valid & {NUM_LANES{reset}};

  // Pick the free flag of the lane the head record targets.
  always_comb begin
    lane_free_sel = 1'b0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (head_lane == LANE_ID_WIDTH'(l)) begin
        lane_free_sel = slot_free[l];
      end
    end
  end

  // Free-running cycle counter; cycle 0 is the first cycle out of reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_counter <= '0;
    end else begin
      cycle_counter <= cycle_counter + 1'b1;
    end
  end

  // Head occupancy and last-record tracking; accept may refill in the cycle the head fires.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_valid <= 1'b0;
      last_seen  <= 1'b0;
    end else if (rec_accept) begin
      head_valid <= 1'b1;
      last_seen  <= rec_last;
    end else if (head_fire) begin
      head_valid <= 1'b0;
    end
  end

  // Head payload capture.
  always_ff @(posedge clock) begin
    if (rec_accept) begin
      head_cycle    <= rec_cycle;
      head_lane     <= rec_lane_id;
      head_source   <= rec_source;
      head_address  <= rec_address;
      head_is_store <= rec_is_store;
      head_size     <= rec_size;
      head_data     <= rec_data;
    end
  end

  // Sticky status: bad-lane drop, trace completion, and saturating stall count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_bad_lane <= 1'b0;
      done         <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (head_fire && head_bad) begin
        err_bad_lane <= 1'b1;
      end
      if (last_seen && !head_valid && (slot_valid == '0)) begin
        done <= 1'b1;
      end
      if (due && !head_fire && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign slot_load[g] = head_fire && !head_bad && (head_lane == LANE_ID_WIDTH'(g));

    mem_trace_lane_slot #(
      .DATA_WIDTH     (DATA_WIDTH),
      .SOURCEID_WIDTH (SOURCEID_WIDTH),
      .LOGSIZE_WIDTH  (LOGSIZE_WIDTH)
    ) u_slot (
      .clock         (clock),
      .reset         (reset),
      .load          (slot_load[g]),
      .load_source   (head_source),
      .load_address  (head_address),
      .load_is_store (head_is_store),
      .load_size     (head_size),
      .load_data     (head_data),
      .ready         (req_ready[g]),
      .valid         (slot_valid[g]),
      .source        (req_source[g*SOURCEID_WIDTH +: SOURCEID_WIDTH]),
      .address       (req_address[g*DATA_WIDTH +: DATA_WIDTH]),
      .is_store      (req_is_store[g]),
      .size          (req_size[g*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]),
      .data          (req_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_mem_trace_player.sv
// Scoreboard bench for mem_trace_player: per-lane expected request queues.
// Latency: checks exact first-valid cycle where the timing is fixed.
// Backpressure: drives per-lane req_ready patterns and checks stall and ordering.
module tb_mem_trace_player;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int SW = 32;
  localparam int LW = 8;
  localparam int IW = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              rec_valid;
  logic              rec_ready;
  logic [DW-1:0]     rec_cycle;
  logic [IW-1:0]     rec_lane_id;
  logic [SW-1:0]     rec_source;
  logic [DW-1:0]     rec_address;
  logic              rec_is_store;
  logic [LW-1:0]     rec_size;
  logic [DW-1:0]     rec_data;
  logic              rec_last;
  logic [NL-1:0]     req_valid;
  logic [NL-1:0]     req_ready;
  logic [SW*NL-1:0]  req_source;
  logic [DW*NL-1:0]  req_address;
  logic [NL-1:0]     req_is_store;
  logic [LW*NL-1:0]  req_size;
  logic [DW*NL-1:0]  req_data;
  logic              done;
  logic              err_bad_lane;
  logic [31:0]       stall_cycles;

  typedef struct {
    logic [SW-1:0] src;
    logic [DW-1:0] addr;
    logic          st;
    logic [LW-1:0] size;
    logic [DW-1:0] data;
    int            exp_cyc;
  } exp_t;

  exp_t lane_q [NL][$];
  bit   seen [NL];
  int   cyc;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_trace_player #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .SOURCEID_WIDTH(SW), .LOGSIZE_WIDTH(LW), .LANE_ID_WIDTH(IW)
  ) dut (
    .clock(clock), .reset(reset),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_cycle(rec_cycle), .rec_lane_id(rec_lane_id),
    .rec_source(rec_source), .rec_address(rec_address), .rec_is_store(rec_is_store),
    .rec_size(rec_size), .rec_data(rec_data), .rec_last(rec_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_source(req_source), .req_address(req_address),
    .req_is_store(req_is_store), .req_size(req_size), .req_data(req_data),
    .done(done), .err_bad_lane(err_bad_lane), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Bench view of the cycle index: 0 in the first cycle after reset release.
  always @(posedge clock) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every valid lane must match the front of its expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        for (int l = 0; l < NL; l++) begin
          if (req_valid[l]) begin
            if (lane_q[l].size() == 0) begin
              check("lane_idle_valid", 64'(req_valid[l]), 64'd0);
            end else begin
              e = lane_q[l][0];
              check("req_source",   64'(req_source[l*SW +: SW]),  64'(e.src));
              check("req_address",  req_address[l*DW +: DW],      e.addr);
              check("req_is_store", 64'(req_is_store[l]),         64'(e.st));
              check("req_size",     64'(req_size[l*LW +: LW]),    64'(e.size));
              check("req_data",     req_data[l*DW +: DW],         e.data);
              if (!seen[l] && e.exp_cyc >= 0) check("issue_cycle", 64'(cyc), 64'(e.exp_cyc));
              seen[l] = 1'b1;
              if (req_ready[l]) begin
                void'(lane_q[l].pop_front());
                seen[l] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_reset();
    reset     = 1'b0;
    rec_valid = 1'b0;
    req_ready = '1;
    repeat (2) @(posedge clock);
    #1;
    for (int l = 0; l < NL; l++) begin
      lane_q[l].delete();
      seen[l] = 1'b0;
    end
    reset = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] c, input int lane, input logic [SW-1:0] src,
                      input logic [DW-1:0] addr, input logic st, input logic [LW-1:0] sz,
                      input logic [DW-1:0] d, input logic last, input int exp_c);
    exp_t e;
    int   n;
    bit   acc;
    if (lane < NL) begin
      e = '{src, addr, st, sz, d, exp_c};
      lane_q[lane].push_back(e);
    end
    rec_valid    = 1'b1;
    rec_cycle    = c;
    rec_lane_id  = IW'(lane);
    rec_source   = src;
    rec_address  = addr;
    rec_is_store = st;
    rec_size     = sz;
    rec_data     = d;
    rec_last     = last;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = rec_ready;
      @(posedge clock);
      #1;
      n++;
    end
    rec_valid = 1'b0;
    if (!acc) check("rec_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain_check();
    for (int l = 0; l < NL; l++) check("queue_drained", 64'(lane_q[l].size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold with a record offered: nothing may be accepted or issued.
    reset = 1'b0; req_ready = '1;
    rec_valid = 1'b1; rec_cycle = '0; rec_lane_id = '0; rec_source = 32'hDEAD;
    rec_address = '0; rec_is_store = 1'b0; rec_size = '0; rec_data = '0; rec_last = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_rec_ready", 64'(rec_ready), 64'd0);
      check("rst_done",      64'(done), 64'd0);
      check("rst_stall",     64'(stall_cycles), 64'd0);
      check("rst_err",       64'(err_bad_lane), 64'd0);
      @(posedge clock); #1;
    end

    // Timed issue: due at cycle 10, visible during cycle 11 only.
    run_reset();
    send(64'd10, 2, 32'h11, 64'h1000, 1'b0, 8'd2, 64'd0, 1'b0, 11);
    wait_cyc(16);
    @(negedge clock);
    check("t1_stall", 64'(stall_cycles), 64'd0);
    check("t1_err",   64'(err_bad_lane), 64'd0);
    check("t1_done",  64'(done), 64'd0);
    drain_check();

    // Backpressure on lane 1 for cycles 0..19; second record stalls cycles 6..19.
    run_reset();
    req_ready = 4'b1101;
    send(64'd5, 1, 32'h21, 64'h2000, 1'b1, 8'd3, 64'hA5A5_0000_1234_5678, 1'b0, 6);
    send(64'd6, 1, 32'h22, 64'h2040, 1'b0, 8'd3, 64'd0, 1'b0, 21);
    wait_cyc(12);
    @(negedge clock);
    check("t2_stall_mid", 64'(stall_cycles), 64'd6);
    wait_cyc(20);
    req_ready = '1;
    wait_cyc(25);
    @(negedge clock);
    check("t2_stall_end", 64'(stall_cycles), 64'd14);
    drain_check();

    // Same-timestamp fan-out: one issue per cycle in input order.
    run_reset();
    for (int l = 0; l < NL; l++)
      send(64'd3, l, 32'h30 + 32'(l), 64'h3000 + 64'(l * 64), 1'(l % 2), 8'(l), 64'(l * 7), 1'b0, 4 + l);
    wait_cyc(12);
    @(negedge clock);
    check("t3_stall", 64'(stall_cycles), 64'd0);
    drain_check();

    // Bad lane is dropped, flagged sticky, and the next record still issues.
    run_reset();
    send(64'd2, 7, 32'h40, 64'h4000, 1'b0, 8'd2, 64'd0, 1'b0, -1);
    send(64'd4, 0, 32'h41, 64'h4100, 1'b1, 8'd1, 64'hFEED, 1'b0, 5);
    wait_cyc(8);
    @(negedge clock);
    check("t4_err", 64'(err_bad_lane), 64'd1);
    wait_cyc(14);
    @(negedge clock);
    check("t4_err_sticky", 64'(err_bad_lane), 64'd1);
    drain_check();

    // Completion: lane 0 blocked until cycle 6, last record reloads on the drain cycle.
    run_reset();
    req_ready = 4'b1110;
    send(64'd1, 0, 32'h51, 64'h5000, 1'b0, 8'd2, 64'd0, 1'b0, 2);
    send(64'd2, 1, 32'h52, 64'h5100, 1'b1, 8'd2, 64'h77, 1'b0, 3);
    send(64'd3, 0, 32'h53, 64'h5200, 1'b1, 8'd3, 64'h99, 1'b1, 7);
    wait_cyc(5);
    @(negedge clock);
    check("t5_done_early", 64'(done), 64'd0);
    wait_cyc(6);
    req_ready = '1;
    wait_cyc(9);
    @(negedge clock);
    check("t5_done", 64'(done), 64'd1);
    @(posedge clock); #1;
    send(64'd20, 2, 32'h54, 64'h5300, 1'b0, 8'd0, 64'd0, 1'b0, 21);
    wait_cyc(25);
    @(negedge clock);
    check("t5_done_sticky", 64'(done), 64'd1);
    check("t5_stall", 64'(stall_cycles), 64'd3);
    drain_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
